multiport_memory_controller: RTL and testbench
==============================================

# multiport_memory_controller

Parametrised successor to the single-port memory controller: arbitrates `NUM_PORTS` requesters onto one internal synchronous memory array. It adds a registered request/acknowledge handshake, configurable read latency and per-port read-valid return. It sits between the CPU-side load/store and fetch units and the memory array, replacing the direct combinational connection.

## Interface
- `MEM_WIDTH`, 32: data word width in bits.
- `MEM_SIZE`, 256: number of words; `AW = $clog2(MEM_SIZE)`.
- `NUM_PORTS`, 2: number of requester ports, ≥1.
- `READ_LATENCY`, 1: cycles from the ACCESS edge to read data valid, ≥1.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `mem_addr` in NUM_PORTS*AW: per-port word address; port p occupies slice [p*AW +: AW].
- `mem_read_en` in NUM_PORTS: per-port read request.
- `mem_write_en` in NUM_PORTS: per-port write request.
- `mem_write_val` in NUM_PORTS*MEM_WIDTH: per-port write data, slice [p*MEM_WIDTH +: MEM_WIDTH].
- `mem_ack` out NUM_PORTS: one-cycle registered pulse; the port's request has been captured.
- `mem_read_val` out MEM_WIDTH: shared read data bus.
- `mem_read_valid` out NUM_PORTS: one-cycle pulse; `mem_read_val` holds data for that port.

## Operation
- FSM states: IDLE, ACCESS, WAIT. Reset state is IDLE.
- **IDLE**
  - At an edge where any port has `mem_read_en` or `mem_write_en` high: arbitrate, latch the winner's port index, op, address and data, and pulse `mem_ack[winner]`. Go to ACCESS.
  - With no request, stay in IDLE.
- **ACCESS**
  - Write: the array is written at this edge, then return to IDLE.
  - Read: the array is read into the read pipeline.
    - If READ_LATENCY==1: raise `mem_read_valid[winner]` and load `mem_read_val` at this edge, then go to IDLE.
    - Otherwise go to WAIT with the counter set to READ_LATENCY-1.
- **WAIT**
  - Decrement the counter each edge.
  - At the edge where the counter reaches 0: load `mem_read_val`, pulse `mem_read_valid[winner]`, go to IDLE.
- **Request rules**
  - A requester holds its enables, address and data stable until it sees `mem_ack`.
  - It may change or drop them in the cycle `mem_ack` is high.
  - Requests are sampled only in IDLE.
  - A request dropped before ack is simply lost; this is legal.
- **Read and write on the same port**: if both enables are high, the op is a write and no read_valid is produced.
- **Address ≥ MEM_SIZE** (non-power-of-2 sizes): the write is discarded, the read returns 0, and ack/valid timing is unchanged.
- `mem_read_val` holds its last value between reads.
- Array contents are not reset.
- **Reset mid-operation**: the FSM returns to IDLE. A write in ACCESS at the reset edge is not committed. No pending ack or valid is issued after reset.

## Timing
- Reset values: `mem_ack`=0, `mem_read_valid`=0, `mem_read_val`=0, state IDLE, round-robin pointer 0.
- Request present at edge E0 (in IDLE): `mem_ack` is high in cycle E0..E1.
- Write: commits at E1. The next request can be captured at E1+1, so write throughput is one per 2 cycles.
- Read: `mem_read_valid` is high in cycle E(READ_LATENCY)..E(READ_LATENCY+1). The next capture can happen at that same valid edge +1, so read throughput is one per READ_LATENCY+1 cycles.
- Only one operation is outstanding at a time. No bypass between ports is needed, because a write always commits before any later read is captured.

## Configuration
- `MEMCTRL_ROUND_ROBIN_EN` defined:
  - Round-robin arbitration. Search starts at the pointer, which is updated to (winner+1) mod NUM_PORTS on each grant.
  - Starvation-free: any held request is granted within NUM_PORTS grants.
- Not defined: fixed priority, where the lowest-indexed requesting port wins. The pointer logic is omitted.

## Test plan
- **Single write then read** (NUM_PORTS=2, READ_LATENCY=1): port0 writes 0xDEADBEEF to addr 5, then reads addr 5.
  - Expect ack at E0 and E2.
  - Expect `mem_read_valid`=2'b01 one cycle after E3 with `mem_read_val`=0xDEADBEEF.
- **Latency sweep**: READ_LATENCY=3, port1 reads addr 7 (holding 0x12345678).
  - Expect valid=2'b10 exactly 3 edges after the capture edge; the value holds after valid drops.
- **Contention**: ports 0 and 1 continuously write to distinct addresses.
  - With the macro defined: grants alternate 0,1,0,1.
  - Without it: port0 is granted every time and port1 never.
- **Simultaneous read and write enables**: port0 asserts both with addr 3 and data 0xA5.
  - Expect a write to occur and no read_valid; a subsequent read of addr 3 returns 0xA5.
- **Reset mid-op**: assert reset at the ACCESS edge of a write to addr 9 (old value 0x11).
  - Expect all outputs 0, state IDLE, and a later read of addr 9 returning 0x11.
- **Out-of-range address** (MEM_SIZE=200): write 0xFF to addr 250, then read addr 250.
  - Expect normal ack/valid timing and read data 0.

Source files
------------

// File: rtl/multiport_memory_controller.sv
// Arbitrated multi-port front end for a single synchronous memory array with
// registered ack, configurable read latency and per-port read-valid return.
// Optional round-robin arbitration: define MEMCTRL_ROUND_ROBIN_EN (else fixed priority).
module multiport_memory_controller #(
  parameter int MEM_WIDTH    = 32,
  parameter int MEM_SIZE     = 256,
  parameter int NUM_PORTS    = 2,
  parameter int READ_LATENCY = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_PORTS*$clog2(MEM_SIZE)-1:0] mem_addr,
  input  logic [NUM_PORTS-1:0]               mem_read_en,
  input  logic [NUM_PORTS-1:0]               mem_write_en,
  input  logic [NUM_PORTS*MEM_WIDTH-1:0]     mem_write_val,
  output logic [NUM_PORTS-1:0]               mem_ack,
  output logic [MEM_WIDTH-1:0]               mem_read_val,
  output logic [NUM_PORTS-1:0]               mem_read_valid
);

  localparam int AW = $clog2(MEM_SIZE);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = $clog2(READ_LATENCY + 1);
  localparam logic [AW:0] SIZE_LIM = (AW+1)'(MEM_SIZE);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;
  state_t state_q, state_d;

  logic [NUM_PORTS-1:0] req;
  logic [AW-1:0]        addr_a  [NUM_PORTS];
  logic [MEM_WIDTH-1:0] wdata_a [NUM_PORTS];
  logic                 any_req;
  logic                 found;
  int                   cand;
  logic [PW-1:0]        win_idx;
  logic [NUM_PORTS-1:0] grant_oh;
  logic [NUM_PORTS-1:0] port_oh;

  logic [PW-1:0]        port_p0;
  logic                 wr_p0;
  logic [AW-1:0]        addr_p0;
  logic [MEM_WIDTH-1:0] wdata_p0;
  logic [MEM_WIDTH-1:0] rd_data_p1;
  logic [CW-1:0]        cnt_q;
  logic                 in_range;
  logic [MEM_WIDTH-1:0] rd_word;

  logic [MEM_WIDTH-1:0] mem [MEM_SIZE];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign req[g]     = mem_read_en[g] | mem_write_en[g];
    assign addr_a[g]  = mem_addr[g*AW +: AW];
    assign wdata_a[g] = mem_write_val[g*MEM_WIDTH +: MEM_WIDTH];
  end

`ifdef MEMCTRL_ROUND_ROBIN_EN
  logic [PW-1:0] rr_ptr;
`endif

  // Arbitration: scan ports starting at the search origin, first requester wins
  always_comb begin
    win_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
`ifdef MEMCTRL_ROUND_ROBIN_EN
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
`else
      cand = i;
`endif
      if (!found && req[PW'(cand)]) begin
        found   = 1'b1;
        win_idx = PW'(cand);
      end
    end
  end

  assign any_req  = |req;
  assign grant_oh = NUM_PORTS'(1) << win_idx;
  assign port_oh  = NUM_PORTS'(1) << port_p0;
  assign in_range = {1'b0, addr_p0} < SIZE_LIM;
  assign rd_word  = in_range ? mem[addr_p0] : '0;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  if (wr_p0 || READ_LATENCY == 1) state_d = IDLE;
               else                            state_d = WAIT;
      WAIT:    if (cnt_q == CW'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: capture of the granted request
  always_ff @(posedge clk) begin
    if (state_q == IDLE && any_req) begin
      port_p0  <= win_idx;
      wr_p0    <= mem_write_en[win_idx];
      addr_p0  <= addr_a[win_idx];
      wdata_p0 <= wdata_a[win_idx];
    end
  end

  // Stage p1: array access; a write at a reset edge must not land
  always_ff @(posedge clk) begin
    if (!reset && state_q == ACCESS && wr_p0 && in_range) mem[addr_p0] <= wdata_p0;
    if (state_q == ACCESS && !wr_p0) rd_data_p1 <= rd_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_ack        <= '0;
      mem_read_valid <= '0;
      mem_read_val   <= '0;
      cnt_q          <= '0;
`ifdef MEMCTRL_ROUND_ROBIN_EN
      rr_ptr         <= '0;
`endif
    end else begin
      mem_ack        <= '0;
      mem_read_valid <= '0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            mem_ack <= grant_oh;
`ifdef MEMCTRL_ROUND_ROBIN_EN
            rr_ptr  <= (win_idx == PW'(NUM_PORTS - 1)) ? '0 : win_idx + PW'(1);
`endif
          end
        end
        ACCESS: begin
          if (!wr_p0) begin
            if (READ_LATENCY == 1) begin
              mem_read_val   <= rd_word;
              mem_read_valid <= port_oh;
            end else begin
              cnt_q <= CW'(READ_LATENCY - 1);
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            mem_read_val   <= rd_data_p1;
            mem_read_valid <= port_oh;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiport_memory_controller.sv
// Directed self-checking bench: one single-latency instance with a non-power-of-2
// array (out-of-range checks) and one READ_LATENCY=3 instance.
module tb_multiport_memory_controller;

  logic        clk = 1'b0;
  logic        reset;

  logic [15:0] a_addr;
  logic [1:0]  a_rd, a_wr, a_ack, a_rvld;
  logic [63:0] a_wv;
  logic [31:0] a_rval;

  logic [15:0] b_addr;
  logic [1:0]  b_rd, b_wr, b_ack, b_rvld;
  logic [63:0] b_wv;
  logic [31:0] b_rval;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multiport_memory_controller #(
    .MEM_WIDTH(32), .MEM_SIZE(200), .NUM_PORTS(2), .READ_LATENCY(1)
  ) u_dut_a (
    .clk(clk), .reset(reset), .mem_addr(a_addr), .mem_read_en(a_rd),
    .mem_write_en(a_wr), .mem_write_val(a_wv), .mem_ack(a_ack),
    .mem_read_val(a_rval), .mem_read_valid(a_rvld)
  );

  multiport_memory_controller #(
    .MEM_WIDTH(32), .MEM_SIZE(256), .NUM_PORTS(2), .READ_LATENCY(3)
  ) u_dut_b (
    .clk(clk), .reset(reset), .mem_addr(b_addr), .mem_read_en(b_rd),
    .mem_write_en(b_wr), .mem_write_val(b_wv), .mem_ack(b_ack),
    .mem_read_val(b_rval), .mem_read_valid(b_rvld)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] exp_grant [4];
`ifdef MEMCTRL_ROUND_ROBIN_EN
    exp_grant = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_grant = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    reset = 1'b1;
    a_addr = '0; a_rd = '0; a_wr = '0; a_wv = '0;
    b_addr = '0; b_rd = '0; b_wr = '0; b_wv = '0;
    tick(); tick();
    chk("reset_a_ack", 32'(a_ack), 32'd0);
    chk("reset_a_valid", 32'(a_rvld), 32'd0);
    chk("reset_a_val", a_rval, 32'd0);
    chk("reset_b_ack", 32'(b_ack), 32'd0);
    chk("reset_b_valid", 32'(b_rvld), 32'd0);
    reset = 1'b0;
    tick();

    // Single write then read on port 0
    a_wr = 2'b01; a_addr[7:0] = 8'd5; a_wv[31:0] = 32'hDEADBEEF;
    tick();
    chk("wr_ack_e0", 32'(a_ack), 32'd1);
    a_wr = 2'b00; a_rd = 2'b01;
    tick();
    chk("wr_access_ack", 32'(a_ack), 32'd0);
    tick();
    chk("rd_ack_e2", 32'(a_ack), 32'd1);
    chk("rd_valid_early", 32'(a_rvld), 32'd0);
    a_rd = 2'b00;
    tick();
    chk("rd_valid", 32'(a_rvld), 32'd1);
    chk("rd_val", a_rval, 32'hDEADBEEF);
    tick();
    chk("rd_valid_drop", 32'(a_rvld), 32'd0);
    chk("rd_val_hold", a_rval, 32'hDEADBEEF);

    // Both enables on port 0: a write, no read-valid
    a_rd = 2'b01; a_wr = 2'b01; a_addr[7:0] = 8'd3; a_wv[31:0] = 32'hA5;
    tick();
    chk("rw_ack", 32'(a_ack), 32'd1);
    a_rd = 2'b00; a_wr = 2'b00;
    tick();
    chk("rw_no_valid_1", 32'(a_rvld), 32'd0);
    tick();
    chk("rw_no_valid_2", 32'(a_rvld), 32'd0);
    chk("rw_val_unchanged", a_rval, 32'hDEADBEEF);
    a_rd = 2'b01;
    tick();
    chk("rw_rd_ack", 32'(a_ack), 32'd1);
    a_rd = 2'b00;
    tick();
    chk("rw_rd_valid", 32'(a_rvld), 32'd1);
    chk("rw_rd_val", a_rval, 32'hA5);

    // Latency 3 instance: port 1 writes then reads addr 7
    b_wr = 2'b10; b_addr[15:8] = 8'd7; b_wv[63:32] = 32'h12345678;
    tick();
    chk("lat_wr_ack", 32'(b_ack), 32'd2);
    b_wr = 2'b00; b_rd = 2'b10;
    tick();
    chk("lat_access_ack", 32'(b_ack), 32'd0);
    tick();
    chk("lat_rd_ack", 32'(b_ack), 32'd2);
    b_rd = 2'b00;
    tick();
    chk("lat_valid_e1", 32'(b_rvld), 32'd0);
    tick();
    chk("lat_valid_e2", 32'(b_rvld), 32'd0);
    tick();
    chk("lat_valid_e3", 32'(b_rvld), 32'd2);
    chk("lat_val_e3", b_rval, 32'h12345678);
    tick();
    chk("lat_valid_drop", 32'(b_rvld), 32'd0);
    chk("lat_val_hold", b_rval, 32'h12345678);

    // Contention from a clean pointer state
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    a_wr = 2'b11;
    a_addr[7:0] = 8'd10;  a_wv[31:0]  = 32'hC0FFEE00;
    a_addr[15:8] = 8'd20; a_wv[63:32] = 32'h0BADF00D;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("grant_%0d", i), 32'(a_ack), 32'(exp_grant[i]));
      tick();
      chk($sformatf("grant_gap_%0d", i), 32'(a_ack), 32'd0);
    end
    a_wr = 2'b00;
    a_rd = 2'b10; a_addr[15:8] = 8'd10;
    tick();
    chk("p1_rd_ack", 32'(a_ack), 32'd2);
    a_rd = 2'b00;
    tick();
    chk("p1_rd_valid", 32'(a_rvld), 32'd2);
    chk("p1_rd_val", a_rval, 32'hC0FFEE00);

    // Reset at the ACCESS edge of a write to addr 9
    a_wr = 2'b01; a_addr[7:0] = 8'd9; a_wv[31:0] = 32'h11;
    tick();
    chk("pre_wr_ack", 32'(a_ack), 32'd1);
    a_wr = 2'b00;
    tick();
    a_wr = 2'b01; a_wv[31:0] = 32'h99;
    tick();
    chk("midop_ack", 32'(a_ack), 32'd1);
    a_wr = 2'b00;
    reset = 1'b1;
    tick();
    chk("midop_rst_ack", 32'(a_ack), 32'd0);
    chk("midop_rst_valid", 32'(a_rvld), 32'd0);
    chk("midop_rst_val", a_rval, 32'd0);
    reset = 1'b0;
    a_rd = 2'b01;
    tick();
    chk("post_rst_ack", 32'(a_ack), 32'd1);
    a_rd = 2'b00;
    tick();
    chk("post_rst_valid", 32'(a_rvld), 32'd1);
    chk("post_rst_val", a_rval, 32'h11);

    // Out-of-range address on the 200-word array
    a_wr = 2'b01; a_addr[7:0] = 8'd250; a_wv[31:0] = 32'hFF;
    tick();
    chk("oor_wr_ack", 32'(a_ack), 32'd1);
    a_wr = 2'b00; a_rd = 2'b01;
    tick();
    chk("oor_access_ack", 32'(a_ack), 32'd0);
    tick();
    chk("oor_rd_ack", 32'(a_ack), 32'd1);
    a_rd = 2'b00;
    tick();
    chk("oor_rd_valid", 32'(a_rvld), 32'd1);
    chk("oor_rd_val", a_rval, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
